// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a show-ahead pixel input.
// Counts x/y over a full frame while running, fetches one pixel per active
// clock, and presents syncs, blanking and 8-bit RGB one clock later, all
// aligned to the same counter cycle.
module vga_timing_gen #(
  parameter int   H_ACTIVE      = 640,
  parameter int   H_SYNC_START  = 656,
  parameter int   H_SYNC_END    = 752,
  parameter int   H_TOTAL       = 800,
  parameter int   V_ACTIVE      = 480,
  parameter int   V_SYNC_START  = 490,
  parameter int   V_SYNC_END    = 492,
  parameter int   V_TOTAL       = 525,
  parameter logic HS_POL        = 1'b0,
  parameter logic VS_POL        = 1'b0,
  parameter int   PREFETCH_LINE = V_TOTAL - 2,
  parameter int   CNT_W         = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fmt_565,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_req,
  output logic        frame_start,
  output logic        running,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
);

  // Parameter sanity: bad timing tables stop elaboration.
  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL))
  begin : g_bad_h_timing
    $error("vga_timing_gen: horizontal timing parameters out of order");
  end
  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL))
  begin : g_bad_v_timing
    $error("vga_timing_gen: vertical timing parameters out of order");
  end
  if (!(V_ACTIVE <= PREFETCH_LINE && PREFETCH_LINE < V_TOTAL)) begin : g_bad_prefetch
    $error("vga_timing_gen: PREFETCH_LINE must lie in the vertical blanking interval");
  end
  if (!((longint'(1) << CNT_W) >= longint'(H_TOTAL) &&
        (longint'(1) << CNT_W) >= longint'(V_TOTAL))) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  // Comparison constants are one bit wider than the counters so a sync end
  // equal to 2^CNT_W still compares correctly.
  localparam int CW1 = CNT_W + 1;
  localparam logic [CW1-1:0] H_ACT_C  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] H_SS_C   = CW1'(H_SYNC_START);
  localparam logic [CW1-1:0] H_SE_C   = CW1'(H_SYNC_END);
  localparam logic [CW1-1:0] H_LAST_C = CW1'(H_TOTAL - 1);
  localparam logic [CW1-1:0] V_ACT_C  = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] V_SS_C   = CW1'(V_SYNC_START);
  localparam logic [CW1-1:0] V_SE_C   = CW1'(V_SYNC_END);
  localparam logic [CW1-1:0] V_LAST_C = CW1'(V_TOTAL - 1);
  localparam logic [CW1-1:0] V_PREF_C = CW1'(PREFETCH_LINE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               fmt_q, fmt_d;
  logic               underflow_q, underflow_d;
  logic               frame_start_q, frame_start_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_n_q, blank_n_d;
  logic [23:0]        rgb_q, rgb_d;

  logic               run;
  logic [CW1-1:0]     x_ext;
  logic [CW1-1:0]     y_ext;
  logic               line_end;
  logic               frame_end;

  // Expand a 16-bit pixel to 24-bit RGB by replicating the top bits of each
  // component into the vacated low bits, so full scale maps to 8'hFF.
  function automatic logic [23:0] expand_pixel(input logic [15:0] d, input logic is_565);
    if (is_565) begin
      return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    end
    return {d[14:10], d[14:12], d[9:5], d[9:7], d[4:0], d[4:2]};
  endfunction

  assign run       = (state_q == RUN);
  assign x_ext     = {1'b0, x_q};
  assign y_ext     = {1'b0, y_q};
  assign line_end  = (x_ext == H_LAST_C);
  assign frame_end = run && line_end && (y_ext == V_LAST_C);

  // The pixel is consumed in the same cycle the counters sit in the active area.
  assign pix_req   = run && (x_ext < H_ACT_C) && (y_ext < V_ACT_C);

  // Next-state logic: FSM, raster counters, format latch, flags and the
  // outputs that are registered one clock behind the counters.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // case/if tree can leave one unassigned and infer a latch.
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    fmt_d         = fmt_q;
    underflow_d   = underflow_q;
    frame_start_d = 1'b0;
    hs_d          = ~HS_POL;
    vs_d          = ~VS_POL;
    blank_n_d     = 1'b0;
    rgb_d         = '0;

    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (enable) begin
          state_d = RUN;
          fmt_d   = fmt_565;
        end
      end
      RUN: begin
        if (line_end) begin
          x_d = '0;
          y_d = (y_ext == V_LAST_C) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        // A frame runs to completion; enable is only honoured at its end,
        // which is also where a new pixel format takes over.
        if (frame_end) begin
          fmt_d = fmt_565;
          if (!enable) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A missing pixel outranks a clear request so no underflow is lost.
    if (pix_req && !pix_valid) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end

    frame_start_d = run && line_end && (y_ext == V_PREF_C);

    if (run && (x_ext >= H_SS_C) && (x_ext < H_SE_C)) begin
      hs_d = HS_POL;
    end
    if (run && (y_ext >= V_SS_C) && (y_ext < V_SE_C)) begin
      vs_d = VS_POL;
    end

    blank_n_d = pix_req;
    if (pix_req && pix_valid) begin
      rgb_d = expand_pixel(pix_data, fmt_q);
    end
  end

  // State and output registers; reset forces a blank, idle, inactive-sync raster.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      fmt_q         <= 1'b0;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fmt_q         <= fmt_d;
      underflow_q   <= underflow_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
    end
  end

  assign running     = run;
  assign underflow   = underflow_q;
  assign frame_start = frame_start_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_SYNC_N  = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 10x8 raster with HS_POL=1.
// Stimulus pushes the expected per-cycle outputs from a frame-position model;
// a negedge monitor pops and compares them against the DUT.
module tb_vga_timing_gen;

  localparam int HA = 6, HSS = 7, HSE = 8, HT = 10;
  localparam int VA = 4, VSS = 5, VSE = 6, VT = 8;
  localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
  localparam int PF = 6;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n, enable, fmt_565, pix_valid, underflow_clr;
  logic [15:0] pix_data;
  logic        pix_req, frame_start, running, underflow;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PREFETCH_LINE(PF), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fmt_565(fmt_565),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_req(pix_req),
    .frame_start(frame_start), .running(running), .underflow(underflow),
    .underflow_clr(underflow_clr), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n),
    .VGA_SYNC_N(vga_sync_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       running, pix_req, frame_start, underflow, hs, vs, blank_n;
    logic [7:0] r, g, b;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0, errors = 0;
  bit   mon_en = 1'b0;
  int   cnt_req, cnt_blank, cnt_hs, cnt_vs, cnt_fs;

  // Stimulus knobs (percent chance of a 1) and fixed-data override.
  int   p_en, p_valid, p_clr, p_fmt;
  bit   data_fixed = 1'b0;
  logic [15:0] data_val = '0;

  // Reference model: position in the frame as a linear clock index.
  bit   m_run, m_fmt, m_uf, m_fs, m_hs, m_vs, m_blank;
  int   m_t;
  logic [7:0] m_r, m_g, m_b;
  bit   cur_run;
  int   cur_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] up5(input int c);
    return 8'((c << 3) | (c >> 2));
  endfunction

  function automatic logic [7:0] up6(input int c);
    return 8'((c << 2) | (c >> 4));
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_fmt = 0; m_uf = 0; m_fs = 0;
    m_hs = !HS_POL; m_vs = !VS_POL; m_blank = 0;
    m_r = '0; m_g = '0; m_b = '0;
  endtask

  function automatic bit model_req();
    return m_run && ((m_t % HT) < HA) && ((m_t / HT) < VA);
  endfunction

  task automatic push_expected();
    exp_t e;
    e.running = m_run; e.pix_req = model_req(); e.frame_start = m_fs;
    e.underflow = m_uf; e.hs = m_hs; e.vs = m_vs; e.blank_n = m_blank;
    e.r = m_r; e.g = m_g; e.b = m_b;
    cur_run = m_run; cur_t = m_t;
    sb_q.push_back(e);
  endtask

  // Drive inputs for the coming edge and move the model past that edge.
  task automatic drive_and_advance();
    int x, y, d;
    bit req;
    enable        = ($urandom_range(99) < p_en);
    pix_valid     = ($urandom_range(99) < p_valid);
    underflow_clr = ($urandom_range(99) < p_clr);
    fmt_565       = ($urandom_range(99) < p_fmt);
    pix_data      = data_fixed ? data_val : 16'($urandom);
    x = m_t % HT; y = m_t / HT; req = model_req(); d = int'(pix_data);
    m_hs = (m_run && x >= HSS && x < HSE) ? HS_POL : !HS_POL;
    m_vs = (m_run && y >= VSS && y < VSE) ? VS_POL : !VS_POL;
    m_blank = req;
    if (req && pix_valid) begin
      if (m_fmt) begin
        m_r = up5((d >> 11) & 31); m_g = up6((d >> 5) & 63); m_b = up5(d & 31);
      end else begin
        m_r = up5((d >> 10) & 31); m_g = up5((d >> 5) & 31); m_b = up5(d & 31);
      end
    end else begin
      m_r = '0; m_g = '0; m_b = '0;
    end
    m_fs = m_run && (x == HT - 1) && (y == PF);
    if (req && !pix_valid) m_uf = 1;
    else if (underflow_clr) m_uf = 0;
    if (!m_run) begin
      m_t = 0;
      if (enable) begin m_run = 1; m_fmt = fmt_565; end
    end else if (m_t == FRAME - 1) begin
      m_t = 0; m_fmt = fmt_565; m_run = enable;
    end else begin
      m_t++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    push_expected();
    drive_and_advance();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_running"}, running, 0);
    check({tag, "_pix_req"}, pix_req, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_underflow"}, underflow, 0);
    check({tag, "_hs"}, vga_hs, !HS_POL);
    check({tag, "_vs"}, vga_vs, !VS_POL);
    check({tag, "_blank_n"}, vga_blank_n, 0);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_sync_n"}, vga_sync_n, 1);
  endtask

  // Monitor: compare every cycle's outputs against the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("running", running, e.running);
      check("pix_req", pix_req, e.pix_req);
      check("frame_start", frame_start, e.frame_start);
      check("underflow", underflow, e.underflow);
      check("vga_hs", vga_hs, e.hs);
      check("vga_vs", vga_vs, e.vs);
      check("blank_n", vga_blank_n, e.blank_n);
      check("vga_r", vga_r, e.r);
      check("vga_g", vga_g, e.g);
      check("vga_b", vga_b, e.b);
      if (pix_req) cnt_req++;
      if (vga_blank_n) cnt_blank++;
      if (vga_hs == HS_POL) cnt_hs++;
      if (vga_vs == VS_POL) cnt_vs++;
      if (frame_start) cnt_fs++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 0; enable = 1; fmt_565 = 0; pix_data = '0; pix_valid = 0; underflow_clr = 0;
    p_en = 100; p_valid = 100; p_clr = 0; p_fmt = 50;
    model_reset();
    #8;
    check_reset_values("por");
    #4;
    rst_n = 1;
    mon_en = 1;
    drive_and_advance();

    // Continuous run with full data, then per-frame totals over one window.
    run_cycles(2 * FRAME);
    cnt_req = 0; cnt_blank = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
    run_cycles(FRAME);
    check("frame_pix_req_count", cnt_req, HA * VA);
    check("frame_blank_n_count", cnt_blank, HA * VA);
    check("frame_hs_active_count", cnt_hs, (HSE - HSS) * VT);
    check("frame_vs_active_count", cnt_vs, (VSE - VSS) * HT);
    check("frame_start_count", cnt_fs, 1);

    // Full-scale colours in both formats.
    data_fixed = 1; data_val = 16'h7FFF; p_fmt = 0;
    run_cycles(2 * FRAME);
    data_val = 16'hF800; p_fmt = 100;
    run_cycles(2 * FRAME);
    data_fixed = 0; p_fmt = 50;

    // Missing pixels and clears, including coincident set/clear.
    p_valid = 90; p_clr = 20;
    run_cycles(4 * FRAME);

    // Enable dropping and returning: frames finish, idle, restart at origin.
    p_en = 40; p_valid = 95; p_clr = 10;
    run_cycles(8 * FRAME);

    // Reset mid-frame at x=5, y=3.
    p_en = 100; p_valid = 100; p_clr = 0;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      cycle();
      if (cur_run && cur_t == 3 * HT + 5) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_point: got not reached expected x=5 y=3");
    end
    #5;
    mon_en = 0;
    rst_n = 0;
    #1;
    check_reset_values("mid_rst");
    sb_q.delete();
    model_reset();
    #20;
    check_reset_values("mid_rst_hold");
    rst_n = 1;
    mon_en = 1;
    drive_and_advance();
    cnt_fs = 0;
    run_cycles(HT * (PF + 1) - 1);
    check("no_frame_start_after_release", cnt_fs, 0);
    run_cycles(2 * FRAME);

    @(posedge clk);
    #6;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
